slc_cand_scheduler: RTL and testbench
=====================================

Name: slc_cand_scheduler

Overview:
- Per-BX scheduler between the sector-logic candidate inputs (3 main primary, 3 main secondary, plus neighbour, minus neighbour) and the single-lane candidate processing pipeline.
- On each bx strobe, snapshots the valid candidates and issues them one per accepted handshake in fixed priority order.
- Applies a configurable per-BX cap and counts candidates lost to the cap or to BX overrun.
- Sits directly downstream of the SLC receiver, ahead of the candidate-manager pipeline.

Parameters:
- N_PRIMARY, 3, candidates per main primary/secondary bus.
- SLC_LEN, SLC_RX_LEN, width of one SLC candidate word.
- VALID_POS, SLC_LEN-1, bit index of the candidate data_valid flag.
- CNT_W, 16, drop counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-low.
- bx  in  1  BX strobe, one clk wide.
- i_enable  in  1  accept new snapshots when 1.
- i_max_cand  in  4  per-BX cap; 0 = forward none; values >8 act as 8.
- i_cnt_clr  in  1  synchronous clear of o_drop_cnt.
- i_main_primary_slc  in  SLC_LEN*N_PRIMARY  candidates 0..2; candidate k at [k*SLC_LEN +: SLC_LEN].
- i_main_secondary_slc  in  SLC_LEN*N_PRIMARY  candidates 3..5, same packing.
- i_plus_neighbor_slc  in  SLC_LEN  candidate 6.
- i_minus_neighbor_slc  in  SLC_LEN  candidate 7.
- o_slc  out  SLC_LEN  issued candidate; 0 when o_slc_valid=0.
- o_slc_valid  out  1  issue valid.
- i_slc_ready  in  1  downstream ready.
- o_slc_src  out  3  source index 0..7 of o_slc.
- o_slc_last  out  1  high with the final candidate of the snapshot.
- o_busy  out  1  pending mask non-zero.
- o_drop_cnt  out  CNT_W  saturating drop count.

Behaviour:
- Reset (rst=0 at a clk edge): all outputs 0, FSM=IDLE, snapshot and mask cleared, effective next cycle.
- Capture: on bx with i_enable=1, latch all 8 words and build raw mask from their VALID_POS bits.
  - Keep the first min(i_max_cand,8) set bits in priority order 0..7.
  - Add the popcount of the removed bits to o_drop_cnt.
- Latency: bx at cycle t -> o_slc_valid=1 at t+1, candidate with the lowest set index.
- FSM IDLE: o_slc_valid=0. On a capture with a non-zero kept mask -> ISSUE. On an empty kept mask, stay IDLE.
- FSM ISSUE:
  - o_slc_valid=1; o_slc/o_slc_src reflect the lowest set bit.
  - o_slc_last=1 when exactly one bit is set.
  - On o_slc_valid & i_slc_ready, clear that bit and present the next one the following cycle.
  - Clearing the last bit -> IDLE.
- Backpressure: while valid & !ready, o_slc, o_slc_src and o_slc_last are held stable. The only exception is overrun.
- Overrun: a new capture while in ISSUE.
  - Bits still set, excluding one accepted in that same cycle, are added to o_drop_cnt.
  - The new snapshot replaces the old one; o_slc may change while valid is held.
  - FSM stays ISSUE, or goes to IDLE if the new kept mask is empty.
- Simultaneous cap drops and overrun drops in one cycle: both are summed into a single update.
- o_drop_cnt saturates at all-ones.
- i_cnt_clr has priority over an increment in the same cycle; the counter reads 0 the next cycle.
- i_enable=0: bx is ignored (no capture, no drops counted); an issue already in progress completes normally.
- o_busy = (mask != 0), registered.

Decomposition:
- Package l0mdt_slc_sched_pkg:
  - source-index enum SRC_PRI0..SRC_PRI2, SRC_SEC0..SRC_SEC2, SRC_PLUS, SRC_MINUS;
  - FSM state enum {IDLE, ISSUE};
  - VALID_POS default.
  - SLC_RX_LEN comes from the existing buses-constants include.
- Sub-module slc_prio_sel (combinational):
  - 8-bit mask in;
  - outputs lowest-set index, one-hot clear vector, popcount, and first-N capped mask.

Test Plan:
1. Candidates 0, 2 and 7 valid, i_max_cand=8, ready=1, bx at t -> valid at t+1..t+3 with src 0, 2, 7; last only at t+3; drop_cnt=0; IDLE at t+4.
2. Candidate 1 valid, ready low t+1..t+3, high at t+4 -> o_slc/src=1 stable t+1..t+4, valid drops at t+5.
3. All 8 valid, i_max_cand=3, ready=1 -> src 0, 1, 2 issued; drop_cnt=5.
4. All 8 valid, cap 8, ready=1, bx at t and t+4 with the second snapshot empty -> src 0..3 at t+1..t+4; drop_cnt=4; IDLE at t+5.
5. rst=0 at t+2 during the test-1 sequence -> at t+3 all outputs 0 and drop_cnt=0; a following bx restarts cleanly.
6. i_enable=0 with bx and 8 valid -> no issue, drop_cnt unchanged. Then i_cnt_clr together with a cap drop -> drop_cnt=0.

Source files
------------

// File: rtl/l0mdt_slc_sched_pkg.sv
// Shared types and constants for the per-BX SLC candidate scheduler.
// SLC_RX_LEN mirrors the value in the buses-constants include.
package l0mdt_slc_sched_pkg;

  localparam int SLC_RX_LEN        = 64;
  localparam int N_SRC             = 8;
  localparam int VALID_POS_DEFAULT = SLC_RX_LEN - 1;

  typedef enum logic [2:0] {
    SRC_PRI0  = 3'd0,
    SRC_PRI1  = 3'd1,
    SRC_PRI2  = 3'd2,
    SRC_SEC0  = 3'd3,
    SRC_SEC1  = 3'd4,
    SRC_SEC2  = 3'd5,
    SRC_PLUS  = 3'd6,
    SRC_MINUS = 3'd7
  } src_e;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

endpackage

// File: rtl/slc_prio_sel.sv
// Fixed-priority helper over an 8-bit candidate mask: lowest set index,
// its one-hot clear vector, popcount, and the first-N-bits capped mask.
module slc_prio_sel
  import l0mdt_slc_sched_pkg::*;
(
  input  logic [N_SRC-1:0] mask_i,
  input  logic [3:0]       cap_i,
  output src_e             low_idx_o,
  output logic [N_SRC-1:0] low_clr_o,
  output logic [3:0]       popcnt_o,
  output logic [N_SRC-1:0] capped_o
);

  logic [3:0] limit;
  logic [3:0] cnt;

  assign limit = (cap_i > 4'd8) ? 4'd8 : cap_i;

  // NOTE: every output gets a default before the loops so no latch is inferred.
  always_comb begin
    low_idx_o = SRC_PRI0;
    low_clr_o = '0;
    capped_o  = '0;
    cnt       = '0;
    // Walk downwards so the last hit is the lowest index.
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (mask_i[k]) low_idx_o = src_e'(k[2:0]);
    end
    if (mask_i != '0) low_clr_o = N_SRC'(1) << low_idx_o;
    for (int k = 0; k < N_SRC; k++) begin
      if (mask_i[k]) begin
        if (cnt < limit) capped_o[k] = 1'b1;
        cnt = cnt + 4'd1;
      end
    end
    popcnt_o = cnt;
  end

endmodule

// File: rtl/slc_cand_scheduler.sv
// Per-BX scheduler: snapshots up to 8 SLC candidates on bx and issues them
// one per handshake in fixed priority order, counting cap and overrun drops.
module slc_cand_scheduler
  import l0mdt_slc_sched_pkg::*;
#(
  parameter int N_PRIMARY = 3,
  parameter int SLC_LEN   = SLC_RX_LEN,
  parameter int VALID_POS = SLC_LEN - 1,
  parameter int CNT_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          bx,
  input  logic                          i_enable,
  input  logic [3:0]                    i_max_cand,
  input  logic                          i_cnt_clr,
  input  logic [SLC_LEN*N_PRIMARY-1:0]  i_main_primary_slc,
  input  logic [SLC_LEN*N_PRIMARY-1:0]  i_main_secondary_slc,
  input  logic [SLC_LEN-1:0]            i_plus_neighbor_slc,
  input  logic [SLC_LEN-1:0]            i_minus_neighbor_slc,
  output logic [SLC_LEN-1:0]            o_slc,
  output logic                          o_slc_valid,
  input  logic                          i_slc_ready,
  output logic [2:0]                    o_slc_src,
  output logic                          o_slc_last,
  output logic                          o_busy,
  output logic [CNT_W-1:0]              o_drop_cnt
);

  state_e             state_q, state_d;
  logic [N_SRC-1:0]   mask_q, mask_d;
  logic [SLC_LEN-1:0] snap_q [N_SRC];
  logic [SLC_LEN-1:0] snap_d [N_SRC];
  logic [SLC_LEN-1:0] word_in [N_SRC];
  logic               busy_q;
  logic [CNT_W-1:0]   drop_q, drop_d;

  logic [N_SRC-1:0]   raw_mask, new_kept, new_clr_unused, cur_clr, cur_capped_unused;
  src_e               new_idx_unused, cur_idx;
  logic [3:0]         new_pop, cur_pop, new_limit, cap_drop, ovr_drop;
  logic               capture, accept;
  logic [4:0]         drop_inc;
  logic [CNT_W:0]     drop_sum;

  always_comb begin
    for (int k = 0; k < N_PRIMARY; k++) begin
      word_in[k]             = i_main_primary_slc[k*SLC_LEN +: SLC_LEN];
      word_in[N_PRIMARY + k] = i_main_secondary_slc[k*SLC_LEN +: SLC_LEN];
    end
    word_in[SRC_PLUS]  = i_plus_neighbor_slc;
    word_in[SRC_MINUS] = i_minus_neighbor_slc;
    for (int k = 0; k < N_SRC; k++) raw_mask[k] = word_in[k][VALID_POS];
  end

  slc_prio_sel u_sel_new (
    .mask_i    (raw_mask),
    .cap_i     (i_max_cand),
    .low_idx_o (new_idx_unused),
    .low_clr_o (new_clr_unused),
    .popcnt_o  (new_pop),
    .capped_o  (new_kept)
  );

  slc_prio_sel u_sel_cur (
    .mask_i    (mask_q),
    .cap_i     (4'd8),
    .low_idx_o (cur_idx),
    .low_clr_o (cur_clr),
    .popcnt_o  (cur_pop),
    .capped_o  (cur_capped_unused)
  );

  assign capture   = bx & i_enable;
  assign accept    = o_slc_valid & i_slc_ready;
  assign new_limit = (i_max_cand > 4'd8) ? 4'd8 : i_max_cand;
  assign cap_drop  = (new_pop > new_limit) ? (new_pop - new_limit) : 4'd0;
  // Overrun loses whatever is still pending, minus a bit accepted this cycle.
  assign ovr_drop  = (capture && state_q == ISSUE) ? (accept ? cur_pop - 4'd1 : cur_pop) : 4'd0;
  assign drop_inc  = capture ? ({1'b0, cap_drop} + {1'b0, ovr_drop}) : 5'd0;
  assign drop_sum  = {1'b0, drop_q} + (CNT_W + 1)'(drop_inc);

  always_comb begin
    if (i_cnt_clr)          drop_d = '0;
    else if (drop_sum[CNT_W]) drop_d = '1;
    else                    drop_d = drop_sum[CNT_W-1:0];
  end

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    snap_d      = snap_q;
    o_slc_valid = 1'b0;
    o_slc       = '0;
    o_slc_src   = '0;
    o_slc_last  = 1'b0;
    case (state_q)
      IDLE: begin
        if (capture) state_d = (new_kept != '0) ? ISSUE : IDLE;
      end
      ISSUE: begin
        o_slc_valid = 1'b1;
        o_slc       = snap_q[cur_idx];
        o_slc_src   = cur_idx;
        o_slc_last  = (cur_pop == 4'd1);
        if (accept) mask_d = mask_q & ~cur_clr;
        state_d = (capture ? (new_kept != '0) : (mask_d != '0)) ? ISSUE : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (capture) begin
      mask_d = new_kept;
      snap_d = word_in;
    end
  end

  // NOTE: state uses non-blocking assignments; the snapshot memory is reset
  // as well so o_slc can never expose stale data after rst.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      mask_q  <= '0;
      busy_q  <= 1'b0;
      drop_q  <= '0;
      for (int k = 0; k < N_SRC; k++) snap_q[k] <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      busy_q  <= (mask_d != '0);
      drop_q  <= drop_d;
      snap_q  <= snap_d;
    end
  end

  assign o_busy     = busy_q;
  assign o_drop_cnt = drop_q;

endmodule

// File: tb/tb_slc_cand_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic against a
// queue-based reference model of the scheduler.
module tb_slc_cand_scheduler;

  localparam int L = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, bx, en, clr, rdy;
  logic [3:0]   maxc;
  logic [L-1:0] w [8];

  logic [3*L-1:0] pri_bus, sec_bus;
  logic [L-1:0]   o_slc;
  logic           o_slc_valid, o_slc_last, o_busy;
  logic [2:0]     o_slc_src;
  logic [15:0]    o_drop_cnt;

  assign pri_bus = {w[2], w[1], w[0]};
  assign sec_bus = {w[5], w[4], w[3]};

  slc_cand_scheduler dut (
    .clk                  (clk),
    .rst                  (rst),
    .bx                   (bx),
    .i_enable             (en),
    .i_max_cand           (maxc),
    .i_cnt_clr            (clr),
    .i_main_primary_slc   (pri_bus),
    .i_main_secondary_slc (sec_bus),
    .i_plus_neighbor_slc  (w[6]),
    .i_minus_neighbor_slc (w[7]),
    .o_slc                (o_slc),
    .o_slc_valid          (o_slc_valid),
    .i_slc_ready          (rdy),
    .o_slc_src            (o_slc_src),
    .o_slc_last           (o_slc_last),
    .o_busy               (o_busy),
    .o_drop_cnt           (o_drop_cnt)
  );

  // Reference model: pending sources in issue order, snapshot words, drop count.
  int           pend[$];
  logic [L-1:0] mw [8];
  int           mdrop;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_outputs();
    bit ev;
    ev = (pend.size() > 0);
    chk("valid", 64'(o_slc_valid), 64'(ev));
    chk("slc",   o_slc, ev ? mw[pend[0]] : 64'd0);
    chk("src",   64'(o_slc_src), ev ? 64'(pend[0]) : 64'd0);
    chk("last",  64'(o_slc_last), 64'(ev && pend.size() == 1));
    chk("busy",  64'(o_busy), 64'(ev));
    chk("drop",  64'(o_drop_cnt), 64'(mdrop));
  endtask

  task automatic model_update();
    int inc, lim;
    if (!rst) begin
      pend.delete();
      mdrop = 0;
      for (int k = 0; k < 8; k++) mw[k] = '0;
      return;
    end
    inc = 0;
    if (pend.size() > 0 && rdy) void'(pend.pop_front());
    if (bx && en) begin
      inc += pend.size();
      pend.delete();
      lim = (int'(maxc) > 8) ? 8 : int'(maxc);
      for (int k = 0; k < 8; k++) begin
        if (w[k][L-1]) begin
          if (pend.size() < lim) pend.push_back(k);
          else inc++;
        end
        mw[k] = w[k];
      end
    end
    if (clr) mdrop = 0;
    else     mdrop = (mdrop + inc > 65535) ? 65535 : mdrop + inc;
  endtask

  task automatic step();
    check_outputs();
    model_update();
    @(posedge clk); #1;
    bx  = 1'b0;
    clr = 1'b0;
  endtask

  task automatic set_words(input logic [7:0] vmask);
    for (int k = 0; k < 8; k++) begin
      w[k]      = {$urandom, $urandom};
      w[k][L-1] = vmask[k];
    end
  endtask

  initial begin
    rst = 1'b0; bx = 1'b0; en = 1'b1; clr = 1'b0; rdy = 1'b1; maxc = 4'd8;
    set_words(8'h00);
    for (int k = 0; k < 8; k++) mw[k] = '0;
    mdrop = 0;
    @(posedge clk); #1;
    step();                             // reset state check
    rst = 1'b1;
    step();

    // 1: candidates 0, 2, 7; full cap; always ready
    set_words(8'b1000_0101); bx = 1'b1;
    repeat (5) step();

    // 2: candidate 1 held under backpressure for three cycles
    set_words(8'b0000_0010); bx = 1'b1; rdy = 1'b1;
    step();
    rdy = 1'b0;
    repeat (3) step();
    rdy = 1'b1;
    repeat (2) step();

    // 3: all valid, cap 3
    set_words(8'hFF); maxc = 4'd3; bx = 1'b1;
    repeat (5) step();

    // 4: all valid, then an empty snapshot overruns after four issues
    set_words(8'hFF); maxc = 4'd8; bx = 1'b1;
    repeat (4) step();
    set_words(8'h00); bx = 1'b1;
    repeat (3) step();

    // 5: reset in the middle of an issue sequence, then a clean restart
    set_words(8'b1000_0101); bx = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    set_words(8'b0100_1001); bx = 1'b1;
    repeat (5) step();

    // 6: disabled bx is ignored; clear wins over a cap drop
    set_words(8'hFF); maxc = 4'd2; bx = 1'b1;
    repeat (3) step();
    en = 1'b0; set_words(8'hFF); bx = 1'b1;
    repeat (3) step();
    en = 1'b1; set_words(8'hFF); maxc = 4'd0; bx = 1'b1; clr = 1'b1;
    repeat (2) step();

    // Cap 9..15 behaves as 8; cap 0 forwards nothing
    set_words(8'hFF); maxc = 4'd15; bx = 1'b1;
    repeat (10) step();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      set_words(8'($urandom));
      bx   = ($urandom_range(0, 3) == 0);
      en   = ($urandom_range(0, 7) != 0);
      maxc = 4'($urandom_range(0, 15));
      rdy  = ($urandom_range(0, 9) < 7);
      clr  = ($urandom_range(0, 49) == 0);
      step();
    end
    rdy = 1'b1; en = 1'b1;
    repeat (10) step();

    // Saturation: 8 cap drops per bx until the counter pins at all-ones
    clr = 1'b1; step();
    maxc = 4'd0;
    for (int i = 0; i < 8195; i++) begin
      set_words(8'hFF); bx = 1'b1;
      step();
    end
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
